// File: rtl/hwag_sync_gen.sv
// -----------------------------------------------------------------------------
// hwag_sync_gen -- tooth-wheel synchroniser and sub-tooth angle interpolator.
//
// Consumes a filtered single-cycle tooth-edge pulse. It measures tooth periods,
// finds the missing-tooth gap, and then tracks the physical tooth index. In the
// SYNC state it splits each tooth period into 2^TICK_SH angle ticks.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   ena_i             block enable; low returns to IDLE and clears all state
//   tooth_edge_i      filtered tooth edge (single-cycle pulse)
//   cfg_min_i/max_i   valid normal tooth period window, clk cycles, inclusive
//   cfg_thnb_i        teeth per revolution including missing teeth
//   cfg_miss_i        missing teeth in the gap (1..3, 0 behaves as 1)
//   state_o           00 IDLE, 01 SEARCH, 10 SYNC
//   synced_o          high while in SYNC
//   tooth_o           physical tooth index, 0 = first tooth after the gap
//   angle_o           tooth<<TICK_SH plus sub-tooth ticks
//   angle_tick_o      one-cycle pulse per angle increment
//   period_o          last captured normal tooth period
//   sync_ev_o         one-cycle pulse on SEARCH->SYNC
//   sync_err_o        one-cycle pulse on SYNC->SEARCH
//
// Optional feature, macro HWAG_ANGLE_CMP_EN: adds cmp_val_i / cmp_hit_o. The
// output cmp_hit_o pulses when the angle becomes equal to cmp_val_i while the
// block is in SYNC.
// -----------------------------------------------------------------------------
module hwag_sync_gen #(
    parameter int PCNT_W  = 24,
    parameter int TCNT_W  = 8,
    parameter int TICK_SH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ena_i,
    input  logic                      tooth_edge_i,
    input  logic [PCNT_W-1:0]         cfg_min_i,
    input  logic [PCNT_W-1:0]         cfg_max_i,
    input  logic [TCNT_W-1:0]         cfg_thnb_i,
    input  logic [1:0]                cfg_miss_i,
    output logic [1:0]                state_o,
    output logic                      synced_o,
    output logic [TCNT_W-1:0]         tooth_o,
    output logic [TCNT_W+TICK_SH-1:0] angle_o,
    output logic                      angle_tick_o,
    output logic [PCNT_W-1:0]         period_o,
    output logic                      sync_ev_o,
    output logic                      sync_err_o
`ifdef HWAG_ANGLE_CMP_EN
    ,
    input  logic [TCNT_W+TICK_SH-1:0] cmp_val_i,
    output logic                      cmp_hit_o
`endif
);

    localparam int AW = TCNT_W + TICK_SH;
    localparam int LW = AW + 1;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SEARCH = 2'b01;
    localparam logic [1:0] ST_SYNC   = 2'b10;

    function automatic logic in_range(input logic [PCNT_W-1:0] v,
                                      input logic [PCNT_W-1:0] lo,
                                      input logic [PCNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [PCNT_W-1:0] cap0_q, cap0_d;
    logic [PCNT_W-1:0] cap1_q, cap1_d;
    logic [1:0]        ccnt_q, ccnt_d;
    logic [TCNT_W-1:0] tooth_q, tooth_d;
    logic [AW-1:0]     angle_q, angle_d;
    logic [PCNT_W-1:0] period_q, period_d;
    logic [PCNT_W-1:0] div_q, div_d;
    logic              tick_q, tick_d;
    logic              ev_q, ev_d;
    logic              err_q, err_d;
    logic              synced_q, synced_d;

    logic [1:0]        miss_s;
    logic [TCNT_W-1:0] gap_tooth_s;
    logic [TCNT_W-1:0] tooth_inc_s;
    logic              gap_exp_s;
    logic              gap_cond_s;
    logic              pcnt_max_s;
    logic [1:0]        ccnt_inc_s;
    logic [PCNT_W-1:0] pcnt_next_s;
    logic [PCNT_W-1:0] reload_s;
    logic              div_term_s;
    logic [LW-1:0]     lim_teeth_s;
    logic [LW-1:0]     lim_s;
    logic              at_lim_s;
    logic              viol_s;

    // Helper terms: gap position, gap test on post-shift captures, interpolator limit.
    always_comb begin
        miss_s      = (cfg_miss_i == 2'd0) ? 2'd1 : cfg_miss_i;
        gap_tooth_s = cfg_thnb_i - TCNT_W'(1'b1) - TCNT_W'(miss_s);
        tooth_inc_s = tooth_q + TCNT_W'(1'b1);
        gap_exp_s   = (tooth_q == gap_tooth_s);
        // After the shift, cap0 = pcnt_q and cap1 = cap0_q (cap2 = cap1_q).
        gap_cond_s  = {1'b0, pcnt_q} > {cap0_q, 1'b0};
        pcnt_max_s  = (pcnt_q == {PCNT_W{1'b1}});
        ccnt_inc_s  = (ccnt_q == 2'd3) ? 2'd3 : (ccnt_q + 2'd1);
        pcnt_next_s = tooth_edge_i ? PCNT_W'(1'b1)
                    : (pcnt_max_s ? pcnt_q : (pcnt_q + PCNT_W'(1'b1)));
        reload_s    = period_q >> TICK_SH;
        if (reload_s == {PCNT_W{1'b0}}) begin
            reload_s = PCNT_W'(1'b1);
        end else begin
            reload_s = period_q >> TICK_SH;
        end
        div_term_s  = ((div_q + PCNT_W'(1'b1)) >= reload_s);
        // The gap interval covers the current tooth plus the missing ones.
        lim_teeth_s = LW'(tooth_q) + LW'(1'b1) + (gap_exp_s ? LW'(miss_s) : LW'(1'b0));
        lim_s       = (lim_teeth_s << TICK_SH) - LW'(1'b1);
        at_lim_s    = (LW'(angle_q) >= lim_s);
        if (gap_exp_s) begin
            viol_s = !gap_cond_s;
        end else begin
            viol_s = !in_range(pcnt_q, cfg_min_i, cfg_max_i) || gap_cond_s;
        end
    end

    // Next-state logic for the sync FSM, capture chain and interpolator.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        cap0_d   = cap0_q;
        cap1_d   = cap1_q;
        ccnt_d   = ccnt_q;
        tooth_d  = tooth_q;
        angle_d  = angle_q;
        period_d = period_q;
        div_d    = div_q;
        tick_d   = 1'b0;
        ev_d     = 1'b0;
        err_d    = 1'b0;
        if (!ena_i) begin
            state_d  = ST_IDLE;
            pcnt_d   = {PCNT_W{1'b0}};
            cap0_d   = {PCNT_W{1'b0}};
            cap1_d   = {PCNT_W{1'b0}};
            ccnt_d   = 2'd0;
            tooth_d  = {TCNT_W{1'b0}};
            angle_d  = {AW{1'b0}};
            period_d = {PCNT_W{1'b0}};
            div_d    = {PCNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    pcnt_d = pcnt_next_s;
                    if (tooth_edge_i) begin
                        cap0_d = pcnt_q;
                        cap1_d = cap0_q;
                        ccnt_d = ccnt_inc_s;
                        if ((ccnt_inc_s == 2'd3) && gap_cond_s &&
                            in_range(cap0_q, cfg_min_i, cfg_max_i) &&
                            in_range(cap1_q, cfg_min_i, cfg_max_i)) begin
                            state_d  = ST_SYNC;
                            ev_d     = 1'b1;
                            tooth_d  = {TCNT_W{1'b0}};
                            angle_d  = {AW{1'b0}};
                            period_d = cap0_q;
                            div_d    = {PCNT_W{1'b0}};
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_SYNC: begin
                    pcnt_d = pcnt_next_s;
                    if (tooth_edge_i) begin
                        // The edge always wins over a coincident divider terminal count.
                        cap0_d = pcnt_q;
                        cap1_d = cap0_q;
                        ccnt_d = ccnt_inc_s;
                        div_d  = {PCNT_W{1'b0}};
                        if (viol_s) begin
                            state_d = ST_SEARCH;
                            err_d   = 1'b1;
                            ccnt_d  = 2'd0;
                        end else if (gap_exp_s) begin
                            tooth_d = {TCNT_W{1'b0}};
                            angle_d = {AW{1'b0}};
                        end else begin
                            tooth_d  = tooth_inc_s;
                            angle_d  = {tooth_inc_s, {TICK_SH{1'b0}}};
                            period_d = pcnt_q;
                        end
                    end else if (pcnt_max_s) begin
                        // No edge for a full counter range: the wheel has stopped.
                        state_d = ST_SEARCH;
                        err_d   = 1'b1;
                        ccnt_d  = 2'd0;
                    end else if (div_term_s) begin
                        div_d = {PCNT_W{1'b0}};
                        if (!at_lim_s) begin
                            tick_d  = 1'b1;
                            angle_d = angle_q + AW'(1'b1);
                        end else begin
                            angle_d = angle_q;
                        end
                    end else begin
                        div_d = div_q + PCNT_W'(1'b1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        synced_d = (state_d == ST_SYNC);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= {PCNT_W{1'b0}};
            cap0_q   <= {PCNT_W{1'b0}};
            cap1_q   <= {PCNT_W{1'b0}};
            ccnt_q   <= 2'd0;
            tooth_q  <= {TCNT_W{1'b0}};
            angle_q  <= {AW{1'b0}};
            period_q <= {PCNT_W{1'b0}};
            div_q    <= {PCNT_W{1'b0}};
            tick_q   <= 1'b0;
            ev_q     <= 1'b0;
            err_q    <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            cap0_q   <= cap0_d;
            cap1_q   <= cap1_d;
            ccnt_q   <= ccnt_d;
            tooth_q  <= tooth_d;
            angle_q  <= angle_d;
            period_q <= period_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            ev_q     <= ev_d;
            err_q    <= err_d;
            synced_q <= synced_d;
        end
    end

    assign state_o      = state_q;
    assign synced_o     = synced_q;
    assign tooth_o      = tooth_q;
    assign angle_o      = angle_q;
    assign angle_tick_o = tick_q;
    assign period_o     = period_q;
    assign sync_ev_o    = ev_q;
    assign sync_err_o   = err_q;

`ifdef HWAG_ANGLE_CMP_EN
    logic cmp_hit_q, cmp_hit_d;

    // Compare hit: only when the angle actually moves (tick or edge reload) in SYNC.
    always_comb begin
        if ((state_d == ST_SYNC) && (tick_d || tooth_edge_i)) begin
            cmp_hit_d = (angle_d == cmp_val_i);
        end else begin
            cmp_hit_d = 1'b0;
        end
    end

    // Compare hit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp_hit_q <= 1'b0;
        end else begin
            cmp_hit_q <= cmp_hit_d;
        end
    end

    assign cmp_hit_o = cmp_hit_q;
`endif

endmodule

// File: tb/tb_hwag_sync_gen.sv
// Directed bench for hwag_sync_gen: reset/enable, lock, interpolation, gap
// interval, loss of sync (range, extra gap, stall) and enable drop.
module tb_hwag_sync_gen;
    localparam int PCNT_W  = 12;
    localparam int TCNT_W  = 8;
    localparam int TICK_SH = 4;
    localparam int AW      = TCNT_W + TICK_SH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              tooth_edge;
    logic [PCNT_W-1:0] cfg_min;
    logic [PCNT_W-1:0] cfg_max;
    logic [TCNT_W-1:0] cfg_thnb;
    logic [1:0]        cfg_miss;
    logic [1:0]        state;
    logic              synced;
    logic [TCNT_W-1:0] tooth;
    logic [AW-1:0]     angle;
    logic              angle_tick;
    logic [PCNT_W-1:0] period;
    logic              sync_ev;
    logic              sync_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ticks, first_tick, ev_cnt, err_cnt, last_angle, err_sum, stall_j;

    hwag_sync_gen #(.PCNT_W(PCNT_W), .TCNT_W(TCNT_W), .TICK_SH(TICK_SH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .tooth_edge_i(tooth_edge),
        .cfg_min_i(cfg_min), .cfg_max_i(cfg_max), .cfg_thnb_i(cfg_thnb),
        .cfg_miss_i(cfg_miss), .state_o(state), .synced_o(synced),
        .tooth_o(tooth), .angle_o(angle), .angle_tick_o(angle_tick),
        .period_o(period), .sync_ev_o(sync_ev), .sync_err_o(sync_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait n-1 quiet cycles, then an edge, so the captured period is n.
    task automatic run_to_edge(input int n);
        ticks = 0; first_tick = 0; ev_cnt = 0; err_cnt = 0;
        for (int j = 1; j < n; j++) begin
            step();
            if (angle_tick) begin
                ticks++;
                if (first_tick == 0) first_tick = j;
            end
            ev_cnt  += int'(sync_ev);
            err_cnt += int'(sync_err);
        end
        last_angle = int'(angle);
        tooth_edge = 1'b1;
        step();
        tooth_edge = 1'b0;
        if (angle_tick) ticks++;
    endtask

    task automatic relock();
        run_to_edge(2);
        run_to_edge(500);
        run_to_edge(500);
        run_to_edge(1500);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; tooth_edge = 1'b0;
        cfg_min = 12'd500; cfg_max = 12'd2000; cfg_thnb = 8'd60; cfg_miss = 2'd2;
        repeat (3) step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_angle", 32'(angle), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_angle", 32'(angle), 32'd0);
            chk("idle_pulses", 32'({angle_tick, sync_ev, sync_err}), 32'd0);
        end
        ena = 1'b1;
        step();
        chk("ena_search", 32'(state), 32'd1);

        // Lock: three normal teeth then a 3000-cycle gap.
        run_to_edge(5);
        run_to_edge(1000);
        run_to_edge(1000);
        chk("pre_gap_state", 32'(state), 32'd1);
        run_to_edge(3000);
        chk("lock_quiet_ev", 32'(ev_cnt), 32'd0);
        chk("lock_sync_ev", 32'(sync_ev), 32'd1);
        chk("lock_state", 32'(state), 32'd2);
        chk("lock_synced", 32'(synced), 32'd1);
        chk("lock_tooth", 32'(tooth), 32'd0);
        chk("lock_angle", 32'(angle), 32'd0);
        chk("lock_period", 32'(period), 32'd1000);

        // Interpolation over tooth 0 at period 1000 (reload 62).
        run_to_edge(1000);
        chk("interp_ticks", 32'(ticks), 32'd15);
        chk("interp_first", 32'(first_tick), 32'd62);
        chk("interp_stall", 32'(last_angle), 32'd15);
        chk("interp_ev_pulse", 32'(ev_cnt), 32'd0);
        chk("interp_reload", 32'(angle), 32'd16);
        chk("interp_tooth", 32'(tooth), 32'd1);

        // Period exactly at cfg_min is valid.
        run_to_edge(500);
        chk("min_period", 32'(period), 32'd500);
        chk("min_tooth", 32'(tooth), 32'd2);
        err_sum = 0;
        for (int i = 0; i < 55; i++) begin
            run_to_edge(500);
            err_sum += err_cnt + int'(sync_err);
        end
        chk("rev_tooth", 32'(tooth), 32'd57);
        chk("rev_no_err", 32'(err_sum), 32'd0);

        // Gap interval: 47 ticks from 912 up to 959 (reload 31), then stall.
        run_to_edge(3000);
        chk("gap_ticks", 32'(ticks), 32'd47);
        chk("gap_stall", 32'(last_angle), 32'd959);
        chk("gap_tooth", 32'(tooth), 32'd0);
        chk("gap_angle", 32'(angle), 32'd0);
        chk("gap_period", 32'(period), 32'd500);
        chk("gap_no_err", 32'(sync_err), 32'd0);
        chk("gap_state", 32'(state), 32'd2);

        // Loss of sync: short period at tooth 20.
        err_sum = 0;
        for (int i = 0; i < 20; i++) begin
            run_to_edge(500);
            err_sum += err_cnt + int'(sync_err);
        end
        chk("t20_tooth", 32'(tooth), 32'd20);
        chk("t20_no_err", 32'(err_sum), 32'd0);
        run_to_edge(300);
        chk("short_err", 32'(sync_err), 32'd1);
        chk("short_state", 32'(state), 32'd1);
        chk("short_synced", 32'(synced), 32'd0);
        step();
        chk("short_err_pulse", 32'(sync_err), 32'd0);

        // Relock, then an unexpected gap at tooth 30.
        relock();
        chk("relock_ev", 32'(sync_ev), 32'd1);
        chk("relock_period", 32'(period), 32'd500);
        for (int i = 0; i < 30; i++) run_to_edge(500);
        chk("t30_tooth", 32'(tooth), 32'd30);
        run_to_edge(1500);
        chk("xgap_err", 32'(sync_err), 32'd1);
        chk("xgap_state", 32'(state), 32'd1);

        // Stall: no edges in SYNC until the period counter saturates.
        step();
        relock();
        chk("stall_lock", 32'(synced), 32'd1);
        stall_j = 0;
        for (int j = 1; j <= 5000; j++) begin
            step();
            if (sync_err === 1'b1) begin
                stall_j = j;
                break;
            end
        end
        chk("stall_cycles", 32'(stall_j), 32'd4095);
        chk("stall_angle", 32'(angle), 32'd15);
        chk("stall_state", 32'(state), 32'd1);

        // Enable drop in SYNC clears everything on the next clock.
        relock();
        chk("drop_lock", 32'(synced), 32'd1);
        repeat (100) step();
        chk("drop_pre_angle", 32'(angle), 32'd3);
        ena = 1'b0;
        step();
        chk("drop_state", 32'(state), 32'd0);
        chk("drop_synced", 32'(synced), 32'd0);
        chk("drop_tooth", 32'(tooth), 32'd0);
        chk("drop_angle", 32'(angle), 32'd0);
        chk("drop_period", 32'(period), 32'd0);
        chk("drop_pulses", 32'({angle_tick, sync_ev, sync_err}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hwag_sync_gen.md
Name: hwag_sync_gen

Overview:
Parametrised successor to the tooth-edge capture/gap-search/tooth-counter chain of the hardware angle generator. It consumes a filtered single-cycle tooth-edge pulse and runs a three-state sync FSM with missing-tooth detection and loss-of-sync detection. It also interpolates each tooth period into 2^TICK_SH angle ticks, so the ignition/injection schedulers downstream get a sub-tooth angle instead of a bare tooth count.

Parameters:
PCNT_W, 24, width of period counter and period registers
TCNT_W, 8, width of tooth index
TICK_SH, 4, log2 of angle ticks per tooth (1..8)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
ena  in  1  block enable; low forces IDLE and clears all state
tooth_edge  in  1  filtered tooth edge, single-cycle pulse
cfg_min  in  PCNT_W  minimum valid normal tooth period, in clk cycles
cfg_max  in  PCNT_W  maximum valid normal tooth period
cfg_thnb  in  TCNT_W  teeth per revolution, missing teeth included (e.g. 60)
cfg_miss  in  2  missing teeth in the gap, 1..3; 0 treated as 1
state  out  2  00 IDLE, 01 SEARCH, 10 SYNC
synced  out  1  state==SYNC
tooth  out  TCNT_W  physical tooth index, 0 = first tooth after gap
angle  out  TCNT_W+TICK_SH  interpolated angle, tooth<<TICK_SH plus sub-tick
angle_tick  out  1  one-cycle pulse on each angle increment
period  out  PCNT_W  last captured normal period
sync_ev  out  1  one-cycle pulse on SEARCH->SYNC
sync_err  out  1  one-cycle pulse on SYNC->SEARCH

Behaviour:
- Reset (rst=0) or ena=0:
  - state=IDLE; all counters, captures, tooth, angle and period cleared to 0.
  - angle_tick, sync_ev and sync_err held at 0.
- ena rising: IDLE->SEARCH on the next clk.
- Period counter:
  - Loads 1 on the cycle of tooth_edge and increments otherwise; saturates at all-ones.
  - On tooth_edge the pre-load value is shifted into cap0; cap0->cap1 and cap1->cap2. cap0 = cycles since the previous edge.
  - A capture counter (saturates at 3) counts edges since entering SEARCH.
- Gap condition: cap0 > 2*cap1, computed at PCNT_W+1 width, evaluated on the updated captures.
- SEARCH -> SYNC: requires all of
  - capture count == 3;
  - gap condition true;
  - cap1 and cap2 each within [cfg_min, cfg_max] inclusive.
  - On entry: sync_ev=1 for one cycle; tooth=0; angle=0; period=cap1.
- SYNC, each tooth_edge:
  - Expected gap edge: edge arriving while tooth == cfg_thnb-1-miss.
  - Normal edge: cap0 must be within [cfg_min, cfg_max]; tooth+1; period=cap0.
  - Gap edge: gap condition must hold; tooth=0; period unchanged.
  - angle reloads to tooth<<TICK_SH on the edge cycle.
  - Any violation (range fail, gap condition where no gap is expected, missing gap) -> SEARCH, sync_err=1 for one cycle, capture count restarts from 0 with captures retained.
  - Period counter saturating while in SYNC -> SEARCH with sync_err.
- Interpolator (SYNC only):
  - Divider reload = period>>TICK_SH, forced to 1 if zero.
  - Divider counts clk cycles and clears on tooth_edge.
  - On reaching the reload value: angle_tick=1, angle+1, divider clears.
  - Angle limit: angle stops (no ticks) at ((tooth+1)<<TICK_SH)-1; in the gap interval the limit is ((tooth+1+miss)<<TICK_SH)-1.
  - Next edge always realigns angle, so late ticks are never emitted after the edge.
- Simultaneous tooth_edge and divider terminal count: the edge wins, no tick is emitted that cycle.
- All outputs are registered; state changes and sync pulses appear 1 clk after the qualifying tooth_edge.

Optional Feature:
HWAG_ANGLE_CMP_EN:
- Defined: adds ports cmp_val (in, TCNT_W+TICK_SH) and cmp_hit (out, 1).
  - cmp_hit pulses for 1 clk when angle becomes equal to cmp_val while in SYNC, whether by tick or by edge reload.
  - No pulse is generated while angle is stalled at the limit.
- Undefined: the ports are absent and the logic is not generated.

Test Plan:
- Reset/enable: rst=0, then rst=1 with ena=0 for 10 clk -> state=00, angle=0, no pulses; ena=1 -> state=01 one clk later.
- Lock: thnb=60, miss=2, min=500, max=2000, edges every 1000 clk with one 3000-clk gap -> sync_ev 1 clk after gap edge, tooth=0, period=1000.
- Interpolation: TICK_SH=4, SYNC with period 1000 -> angle_tick every 62 clk, 15 ticks per tooth, angle stops at 15 then reloads to 16 on the next edge.
- Gap interval: tooth=57 with a 3000-clk gap -> angle reaches 16*60-1=959 (no further ticks); gap edge -> tooth=0, angle=0, no sync_err.
- Loss of sync: in SYNC at tooth 20, one period=300 (<min) -> sync_err 1 clk, state=01; extra gap at tooth 30 -> sync_err.
- Stall/enable drop: edges stop in SYNC -> sync_err at counter saturation; ena=0 mid-SYNC -> IDLE next clk with all outputs 0.
